// File: rtl/float_add16.sv
// Registered IEEE 754 binary16 adder with round-to-nearest-even, one clock of latency.
// Accumulation primitive for the convolution datapath; subnormals handled without flush-to-zero.
module float_add16 #(
    parameter int DATA_WIDTH = 16,
    parameter int EXP_WIDTH  = 5,
    parameter int MAN_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] floatA,
    input  logic [DATA_WIDTH-1:0] floatB,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  out_valid
);
    localparam int SIG_W = MAN_WIDTH + 1;
    localparam int EXT_W = SIG_W + 3;
    localparam int AL_W  = SIG_W + EXT_W - 1;
    localparam int E_W   = EXP_WIDTH + 1;
    localparam logic [EXP_WIDTH-1:0]  EXP_ALL1  = '1;
    localparam logic [EXP_WIDTH-1:0]  SHIFT_OUT = EXP_WIDTH'(EXT_W);
    localparam logic [DATA_WIDTH-1:0] QNAN      = {1'b0, EXP_ALL1, 1'b1, {(MAN_WIDTH-1){1'b0}}};

    logic                  sign_a, sign_b;
    logic [EXP_WIDTH-1:0]  exp_a, exp_b;
    logic [MAN_WIDTH-1:0]  man_a, man_b;
    logic                  nan_a, nan_b, inf_a, inf_b;

    logic                  a_big, eff_sub;
    logic                  sign_big;
    logic [EXP_WIDTH-1:0]  exp_big, exp_sml, e_big, e_sml, exp_diff;
    logic [MAN_WIDTH-1:0]  man_big, man_sml;
    logic [SIG_W-1:0]      sig_big, sig_sml;

    logic [AL_W-1:0]       shifted;
    logic [EXT_W-1:0]      big_ext, sml_al;
    logic [EXT_W:0]        raw;

    logic [E_W-1:0]        lz, lim, lz_w, sh;
    logic [EXT_W-1:0]      norm;
    logic [E_W-1:0]        norm_exp;

    logic                  rnd_up;
    logic [SIG_W:0]        mant_r;
    logic [SIG_W-1:0]      mant_f;
    logic [E_W-1:0]        exp_f;
    logic                  overflow;
    logic [EXP_WIDTH-1:0]  res_exp;

    logic [DATA_WIDTH-1:0] sum_d, sum_q;
    logic                  out_valid_q;

    function automatic logic [E_W-1:0] lzc(input logic [EXT_W-1:0] v);
        lzc = E_W'(EXT_W);
        for (int i = 0; i < EXT_W; i++) begin
            if (v[i]) lzc = E_W'(EXT_W - 1 - i);
        end
    endfunction

    assign sign_a = floatA[DATA_WIDTH-1];
    assign sign_b = floatB[DATA_WIDTH-1];
    assign exp_a  = floatA[DATA_WIDTH-2 -: EXP_WIDTH];
    assign exp_b  = floatB[DATA_WIDTH-2 -: EXP_WIDTH];
    assign man_a  = floatA[MAN_WIDTH-1:0];
    assign man_b  = floatB[MAN_WIDTH-1:0];

    assign nan_a = (exp_a == EXP_ALL1) && (man_a != '0);
    assign nan_b = (exp_b == EXP_ALL1) && (man_b != '0);
    assign inf_a = (exp_a == EXP_ALL1) && (man_a == '0);
    assign inf_b = (exp_b == EXP_ALL1) && (man_b == '0);

    // Exponent-then-mantissa ordering is exactly the unsigned order of the low 15 bits.
    assign a_big    = floatA[DATA_WIDTH-2:0] >= floatB[DATA_WIDTH-2:0];
    assign eff_sub  = sign_a ^ sign_b;
    assign sign_big = a_big ? sign_a : sign_b;
    assign exp_big  = a_big ? exp_a : exp_b;
    assign man_big  = a_big ? man_a : man_b;
    assign exp_sml  = a_big ? exp_b : exp_a;
    assign man_sml  = a_big ? man_b : man_a;

    assign e_big    = (exp_big == '0) ? EXP_WIDTH'(1) : exp_big;
    assign e_sml    = (exp_sml == '0) ? EXP_WIDTH'(1) : exp_sml;
    assign sig_big  = {exp_big != '0, man_big};
    assign sig_sml  = {exp_sml != '0, man_sml};
    assign exp_diff = e_big - e_sml;

    always_comb begin
        shifted = {sig_sml, {(EXT_W-1){1'b0}}} >> exp_diff;
        if (exp_diff >= SHIFT_OUT) begin
            sml_al = {{(EXT_W-1){1'b0}}, |sig_sml};
        end else begin
            sml_al = {shifted[AL_W-1:SIG_W], |shifted[SIG_W-1:0]};
        end
    end

    assign big_ext = {sig_big, {(EXT_W-SIG_W){1'b0}}};
    assign raw     = eff_sub ? ({1'b0, big_ext} - {1'b0, sml_al})
                             : ({1'b0, big_ext} + {1'b0, sml_al});

    // Left normalisation stops at exponent 1 so deep cancellation lands as a subnormal.
    always_comb begin
        lz       = lzc(raw[EXT_W-1:0]);
        lim      = {1'b0, e_big} - E_W'(1);
        lz_w     = lz;
        sh       = (lz_w > lim) ? lim : lz_w;
        norm     = raw[EXT_W-1:0];
        norm_exp = {1'b0, e_big};
        if (!eff_sub && raw[EXT_W]) begin
            norm     = {raw[EXT_W:2], raw[1] | raw[0]};
            norm_exp = {1'b0, e_big} + E_W'(1);
        end else if (eff_sub) begin
            norm     = raw[EXT_W-1:0] << sh;
            norm_exp = {1'b0, e_big} - sh;
        end
    end

    always_comb begin
        rnd_up = norm[2] & (norm[3] | norm[1] | norm[0]);
        mant_r = {1'b0, norm[EXT_W-1:3]} + {{SIG_W{1'b0}}, rnd_up};
        if (mant_r[SIG_W]) begin
            mant_f = mant_r[SIG_W:1];
            exp_f  = norm_exp + E_W'(1);
        end else begin
            mant_f = mant_r[SIG_W-1:0];
            exp_f  = norm_exp;
        end
    end

    assign overflow = exp_f >= {1'b0, EXP_ALL1};
    assign res_exp  = mant_f[MAN_WIDTH] ? exp_f[EXP_WIDTH-1:0] : '0;

    always_comb begin
        sum_d = {sign_big, res_exp, mant_f[MAN_WIDTH-1:0]};
        if (nan_a || nan_b) begin
            sum_d = QNAN;
        end else if (inf_a && inf_b && (sign_a != sign_b)) begin
            sum_d = QNAN;
        end else if (inf_a) begin
            sum_d = floatA;
        end else if (inf_b) begin
            sum_d = floatB;
        end else if (eff_sub && (raw == '0)) begin
            sum_d = '0;
        end else if (overflow) begin
            sum_d = {sign_big, EXP_ALL1, {MAN_WIDTH{1'b0}}};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) sum_q <= sum_d;
        end
    end

    assign sum       = sum_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_float_add16.sv
// Scoreboard bench for float_add16: directed cases plus random pairs checked against
// an exact-integer binary16 round-to-nearest-even reference.
module tb_float_add16;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] floatA, floatB;
    logic [15:0] sum;
    logic        out_valid;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];

    float_add16 dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .floatA(floatA), .floatB(floatB), .sum(sum), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Magnitude in units of 2^-24 (the smallest subnormal).
    function automatic longint mag16(input logic [15:0] x);
        if (x[14:10] == 5'd0) return longint'(x[9:0]);
        return longint'({1'b1, x[9:0]}) << (x[14:10] - 5'd1);
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        logic   nan_a, nan_b, inf_a, inf_b, sgn;
        longint s, m, q, rem, half;
        int     p, sh, be;
        nan_a = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        nan_b = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        inf_a = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
        inf_b = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
        if (nan_a || nan_b) return 16'h7E00;
        if (inf_a && inf_b) return (a[15] == b[15]) ? a : 16'h7E00;
        if (inf_a) return a;
        if (inf_b) return b;
        s = (a[15] ? -mag16(a) : mag16(a)) + (b[15] ? -mag16(b) : mag16(b));
        if (s == 0) return (a[15] && b[15]) ? 16'h8000 : 16'h0000;
        sgn = (s < 0);
        m   = sgn ? -s : s;
        p   = 0;
        for (int i = 0; i < 48; i++) if (m[i]) p = i;
        if (p < 10) return {sgn, 5'd0, m[9:0]};
        sh  = p - 10;
        q   = m >> sh;
        rem = m - (q << sh);
        if (sh > 0) begin
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
        end
        if (q == 2048) begin
            q = 1024;
            p = p + 1;
        end
        be = p - 9;
        if (be >= 31) return sgn ? 16'hFC00 : 16'h7C00;
        return {sgn, be[4:0], q[9:0]};
    endfunction

    // Drive one operation for a single cycle and queue its expected sum.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
        @(negedge clk);
        in_valid = 1'b1;
        floatA   = a;
        floatB   = b;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        floatA   = 16'h0;
        floatB   = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (sum !== 16'h0000 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_held: sum=%h out_valid=%b, want sum=0000 out_valid=0", sum, out_valid);
        end
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (sum !== 16'h0000 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: sum=%h out_valid=%b, want sum=0000 out_valid=0", sum, out_valid);
        end
    endtask

    task automatic test_basic();
        logic [15:0] ta[3] = '{16'h3C00, 16'h4000, 16'h4000};
        logic [15:0] tb[3] = '{16'h3C00, 16'h3C00, 16'h4000};
        logic [15:0] te[3] = '{16'h4000, 16'h4200, 16'h4400};
        logic [15:0] want;
        for (int i = 0; i < 3; i++) begin
            issue(ta[i], tb[i], te[i]);
            want = exp_q.pop_front();
            n_vec++;
            if (out_valid !== 1'b1 || sum !== want) begin
                n_err++;
                $display("FAIL basic[%0d]: sum=%h out_valid=%b, want sum=%h out_valid=1", i, sum, out_valid, want);
            end
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b0 || sum !== want) begin
                n_err++;
                $display("FAIL basic_hold[%0d]: sum=%h out_valid=%b, want sum=%h out_valid=0", i, sum, out_valid, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ta[4] = '{16'h3C00, 16'h4000, 16'h4000, 16'h4200};
        logic [15:0] tb[4] = '{16'h3C00, 16'h3C00, 16'h4000, 16'hBC00};
        logic [15:0] te[4] = '{16'h4000, 16'h4200, 16'h4400, 16'h4000};
        logic [15:0] want;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                want = exp_q.pop_front();
                n_vec++;
                if (out_valid !== 1'b1 || sum !== want) begin
                    n_err++;
                    $display("FAIL back_to_back[%0d]: sum=%h out_valid=%b, want sum=%h out_valid=1", i - 1, sum, out_valid, want);
                end
            end
            if (i < 4) begin
                in_valid = 1'b1;
                floatA   = ta[i];
                floatB   = tb[i];
                exp_q.push_back(te[i]);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL back_to_back_idle: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_signs();
        logic [15:0] ta[5] = '{16'h3C00, 16'h8000, 16'h4200, 16'hBC00, 16'h0000};
        logic [15:0] tb[5] = '{16'hBC00, 16'h8000, 16'hBC00, 16'h3800, 16'h8000};
        logic [15:0] te[5] = '{16'h0000, 16'h8000, 16'h4000, 16'hB800, 16'h0000};
        logic [15:0] want;
        for (int i = 0; i < 5; i++) begin
            issue(ta[i], tb[i], te[i]);
            want = exp_q.pop_front();
            n_vec++;
            if (out_valid !== 1'b1 || sum !== want) begin
                n_err++;
                $display("FAIL signs[%0d]: sum=%h out_valid=%b, want sum=%h out_valid=1", i, sum, out_valid, want);
            end
        end
    endtask

    task automatic test_rounding();
        logic [15:0] ta[4] = '{16'h3C00, 16'h3C01, 16'h3C00, 16'h3C00};
        logic [15:0] tb[4] = '{16'h1000, 16'h1000, 16'h1001, 16'h9001};
        logic [15:0] te[4] = '{16'h3C00, 16'h3C02, 16'h3C01, 16'h3BFF};
        logic [15:0] want;
        for (int i = 0; i < 4; i++) begin
            issue(ta[i], tb[i], te[i]);
            want = exp_q.pop_front();
            n_vec++;
            if (out_valid !== 1'b1 || sum !== want) begin
                n_err++;
                $display("FAIL rounding[%0d]: sum=%h out_valid=%b, want sum=%h out_valid=1", i, sum, out_valid, want);
            end
        end
    endtask

    task automatic test_subnormal_overflow();
        logic [15:0] ta[5] = '{16'h0001, 16'h03FF, 16'h7BFF, 16'hFBFF, 16'h0400};
        logic [15:0] tb[5] = '{16'h0001, 16'h0001, 16'h7BFF, 16'hFBFF, 16'h83FF};
        logic [15:0] te[5] = '{16'h0002, 16'h0400, 16'h7C00, 16'hFC00, 16'h0001};
        logic [15:0] want;
        for (int i = 0; i < 5; i++) begin
            issue(ta[i], tb[i], te[i]);
            want = exp_q.pop_front();
            n_vec++;
            if (out_valid !== 1'b1 || sum !== want) begin
                n_err++;
                $display("FAIL subnormal_overflow[%0d]: sum=%h out_valid=%b, want sum=%h out_valid=1", i, sum, out_valid, want);
            end
        end
    endtask

    task automatic test_specials();
        logic [15:0] ta[5] = '{16'h7C00, 16'h7C00, 16'h7E01, 16'hFC00, 16'h3C00};
        logic [15:0] tb[5] = '{16'h3C00, 16'hFC00, 16'h3C00, 16'hFC00, 16'h7E01};
        logic [15:0] te[5] = '{16'h7C00, 16'h7E00, 16'h7E00, 16'hFC00, 16'h7E00};
        logic [15:0] want;
        for (int i = 0; i < 5; i++) begin
            issue(ta[i], tb[i], te[i]);
            want = exp_q.pop_front();
            n_vec++;
            if (out_valid !== 1'b1 || sum !== want) begin
                n_err++;
                $display("FAIL specials[%0d]: sum=%h out_valid=%b, want sum=%h out_valid=1", i, sum, out_valid, want);
            end
        end
    endtask

    // Even slots issue (a,b), odd slots issue (b,a); each pair must match the model and each other.
    task automatic test_random(input int n_pairs);
        logic [15:0] a, b, want, prev_sum;
        a = 16'h0;
        b = 16'h0;
        prev_sum = 16'h0;
        for (int i = 0; i <= 2 * n_pairs; i++) begin
            @(negedge clk);
            if (i > 0) begin
                want = exp_q.pop_front();
                n_vec++;
                if (out_valid !== 1'b1 || sum !== want) begin
                    n_err++;
                    $display("FAIL random[%0d]: A=%h B=%h sum=%h out_valid=%b, want sum=%h", i - 1, floatA, floatB, sum, out_valid, want);
                end
                if ((i % 2) == 0) begin
                    n_vec++;
                    if (sum !== prev_sum) begin
                        n_err++;
                        $display("FAIL commute[%0d]: sum=%h, want same as swapped order %h", i - 1, sum, prev_sum);
                    end
                end
                prev_sum = sum;
            end
            if (i < 2 * n_pairs) begin
                if ((i % 2) == 0) begin
                    a = 16'($urandom);
                    case ($urandom_range(0, 3))
                        0: b = 16'($urandom);
                        1: b = a ^ 16'h8000 ^ (16'($urandom) & 16'h001F);
                        2: b = {1'($urandom), a[14:10] - 5'($urandom_range(0, 3)), 10'($urandom)};
                        default: begin
                            a = {1'($urandom), 5'($urandom_range(0, 2)), 10'($urandom)};
                            b = {1'($urandom), 5'($urandom_range(0, 2)), 10'($urandom)};
                        end
                    endcase
                end
                in_valid = 1'b1;
                floatA   = ((i % 2) == 0) ? a : b;
                floatB   = ((i % 2) == 0) ? b : a;
                exp_q.push_back(ref_add(a, b));
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_valid = 1'b1;
        floatA   = 16'h3C00;
        floatB   = 16'h3C00;
        @(posedge clk);
        #2;
        n_vec++;
        if (out_valid !== 1'b1 || sum !== 16'h4000) begin
            n_err++;
            $display("FAIL async_pre: sum=%h out_valid=%b, want sum=4000 out_valid=1", sum, out_valid);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || sum !== 16'h0000) begin
            n_err++;
            $display("FAIL async_clear: sum=%h out_valid=%b, want sum=0000 out_valid=0", sum, out_valid);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || sum !== 16'h0000) begin
            n_err++;
            $display("FAIL async_hold: sum=%h out_valid=%b, want sum=0000 out_valid=0", sum, out_valid);
        end
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || sum !== 16'h0000) begin
            n_err++;
            $display("FAIL async_release: sum=%h out_valid=%b, want sum=0000 out_valid=0", sum, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_signs();
        test_rounding();
        test_subnormal_overflow();
        test_specials();
        test_random(10000);
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
